// File: rtl/time_alarm_if.sv
// Control and display bundle between the UI sequencer and the time/alarm core.
// The master drives edit/commit controls; the slave returns the display digits and status.
interface time_alarm_if;
  logic       increment_seconds_en;
  logic       increment_minutes_en;
  logic       increment_hours_en;
  logic       load_time_en;
  logic       set_alarm_mode;
  logic [2:0] display_mode_in;
  logic       alarm_en;
  logic       alarm_ack;
  logic [4:0] disp_hours;
  logic [5:0] disp_minutes;
  logic [5:0] disp_seconds;
  logic       sec_tick;
  logic       alarm_active;

  modport master (
    output increment_seconds_en, increment_minutes_en, increment_hours_en,
           load_time_en, set_alarm_mode, display_mode_in, alarm_en, alarm_ack,
    input  disp_hours, disp_minutes, disp_seconds, sec_tick, alarm_active
  );

  modport slave (
    input  increment_seconds_en, increment_minutes_en, increment_hours_en,
           load_time_en, set_alarm_mode, display_mode_in, alarm_en, alarm_ack,
    output disp_hours, disp_minutes, disp_seconds, sec_tick, alarm_active
  );
endinterface

// File: rtl/time_alarm_core.sv
// Live HH:MM:SS clock with editable shadow time, alarm compare/ring timer and display mux.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ALM_IDLE  | alarm silent, waiting for a tick that lands on alarm time
// ALM_RING  | alarm_active high, ring counter counting sec_ticks
module time_alarm_core #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int ALARM_SECS = 60
) (
  input logic        sys_clk,
  input logic        rst,
  time_alarm_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(ALARM_SECS + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(ALARM_SECS - 1);

  typedef enum logic {ALM_IDLE, ALM_RING} alm_state_t;

  logic [PW-1:0] pre_cnt;
  logic          sec_tick;
  logic [4:0]    live_hh, shd_hh, alm_hh, tick_hh;
  logic [5:0]    live_mm, shd_mm, alm_mm, tick_mm;
  logic [5:0]    live_ss, shd_ss, tick_ss;
  logic [RW-1:0] ring_cnt;
  logic          ring_clr, ring_inc, alarm_hit, tick_go;
  alm_state_t    alm_state, alm_next;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  // A commit wins over a coincident second increment.
  assign tick_go = sec_tick && !bus.load_time_en;

  always_comb begin
    tick_ss = inc60(live_ss);
    tick_mm = (live_ss == 6'd59) ? inc60(live_mm) : live_mm;
    tick_hh = (live_ss == 6'd59 && live_mm == 6'd59) ? inc24(live_hh) : live_hh;
  end

  assign alarm_hit = tick_go && bus.alarm_en && (tick_hh == alm_hh) &&
                     (tick_mm == alm_mm) && (tick_ss == 6'd0);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= (pre_cnt == PRE_LAST) && !bus.load_time_en;
      if (bus.load_time_en || pre_cnt == PRE_LAST) pre_cnt <= '0;
      else                                         pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      live_hh <= '0;
      live_mm <= '0;
      live_ss <= '0;
    end else if (bus.load_time_en) begin
      live_hh <= shd_hh;
      live_mm <= shd_mm;
      live_ss <= shd_ss;
    end else if (sec_tick) begin
      live_hh <= tick_hh;
      live_mm <= tick_mm;
      live_ss <= tick_ss;
    end
  end

  // Shadow follows live in the normal display mode; edits never carry between fields.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      shd_hh <= '0;
      shd_mm <= '0;
      shd_ss <= '0;
    end else if (bus.display_mode_in == 3'b000) begin
      shd_hh <= live_hh;
      shd_mm <= live_mm;
      shd_ss <= live_ss;
    end else if (!bus.set_alarm_mode) begin
      if (bus.increment_hours_en)   shd_hh <= inc24(shd_hh);
      if (bus.increment_minutes_en) shd_mm <= inc60(shd_mm);
      if (bus.increment_seconds_en) shd_ss <= inc60(shd_ss);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      alm_hh <= '0;
      alm_mm <= '0;
    end else if (bus.set_alarm_mode) begin
      if (bus.increment_hours_en)   alm_hh <= inc24(alm_hh);
      if (bus.increment_minutes_en) alm_mm <= inc60(alm_mm);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      alm_state <= ALM_IDLE;
      ring_cnt  <= '0;
    end else begin
      alm_state <= alm_next;
      if (ring_clr)      ring_cnt <= '0;
      else if (ring_inc) ring_cnt <= ring_cnt + 1'b1;
    end
  end

  // Silencing (ack or disarm) takes priority, so an ack on the trigger cycle keeps it quiet.
  always_comb begin
    alm_next = alm_state;
    ring_clr = 1'b0;
    ring_inc = 1'b0;
    if (!bus.alarm_en || bus.alarm_ack) begin
      alm_next = ALM_IDLE;
    end else if (alarm_hit) begin
      alm_next = ALM_RING;
      ring_clr = 1'b1;
    end else if (alm_state == ALM_RING && sec_tick) begin
      if (ring_cnt == RING_LAST) alm_next = ALM_IDLE;
      else                       ring_inc = 1'b1;
    end
  end

  always_comb begin
    bus.disp_hours   = live_hh;
    bus.disp_minutes = live_mm;
    bus.disp_seconds = live_ss;
    case (bus.display_mode_in)
      3'b001, 3'b010: begin
        bus.disp_hours   = shd_hh;
        bus.disp_minutes = shd_mm;
        bus.disp_seconds = shd_ss;
      end
      3'b011, 3'b100: begin
        bus.disp_hours   = alm_hh;
        bus.disp_minutes = alm_mm;
        bus.disp_seconds = 6'd0;
      end
      default: ;
    endcase
  end

  assign bus.sec_tick     = sec_tick;
  assign bus.alarm_active = (alm_state == ALM_RING);
endmodule

// File: tb/tb_time_alarm_core.sv
// Directed bench for time_alarm_core with TICK_DIV=4, ALARM_SECS=3; expectations go through a queue.
module tb_time_alarm_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_alarm_if bus();

  time_alarm_core #(.TICK_DIV(4), .ALARM_SECS(3)) dut (
    .sys_clk(clk),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] tm(input int h, input int m, input int s);
    return {15'd0, 5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [31:0] obs_time();
    return {15'd0, bus.disp_hours, bus.disp_minutes, bus.disp_seconds};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      e.tag = "scoreboard_empty";
      e.val = 'x;
    end else begin
      e = sb.pop_front();
    end
    n_cmp++;
    assert (got === e.val) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, got, e.val);
    end
  endtask

  task automatic pulse_load();
    bus.load_time_en = 1'b1;
    tick();
    bus.load_time_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks, last, badgap, found;
    bus.increment_seconds_en = 1'b0;
    bus.increment_minutes_en = 1'b0;
    bus.increment_hours_en   = 1'b0;
    bus.load_time_en         = 1'b0;
    bus.set_alarm_mode       = 1'b0;
    bus.display_mode_in      = 3'b000;
    bus.alarm_en             = 1'b0;
    bus.alarm_ack            = 1'b0;
    tick(3);
    push("rst_time", tm(0, 0, 0));  pop_check(obs_time());
    push("rst_tick", 0);            pop_check(bus.sec_tick);
    push("rst_alarm", 0);           pop_check(bus.alarm_active);
    rst = 1'b0;

    // 60 seconds of free running
    ticks = 0; last = -1; badgap = 0;
    push("tick_count", 60);
    push("tick_gap", 0);
    push("run60_time", tm(0, 1, 0));
    for (int c = 1; c <= 241; c++) begin
      tick();
      if (bus.sec_tick) begin
        if ((last < 0 && c != 4) || (last >= 0 && c - last != 4)) badgap++;
        ticks++;
        last = c;
      end
    end
    pop_check(ticks);
    pop_check(badgap);
    pop_check(obs_time());

    // edit shadow to 23:59:58 and commit, then roll over midnight
    tick();
    bus.display_mode_in = 3'b001; #1;
    push("shadow_init", tm(0, 1, 0)); pop_check(obs_time());
    push("shadow_edit", tm(23, 59, 58));
    for (int i = 0; i < 58; i++) begin
      bus.increment_hours_en   = (i < 23);
      bus.increment_minutes_en = 1'b1;
      bus.increment_seconds_en = 1'b1;
      tick();
    end
    bus.increment_hours_en = 1'b0; bus.increment_minutes_en = 1'b0; bus.increment_seconds_en = 1'b0;
    pop_check(obs_time());
    push("load_time", tm(23, 59, 58));
    push("load_tick_sup", 0);
    pulse_load();
    bus.display_mode_in = 3'b000; #1;
    pop_check(obs_time());
    pop_check(bus.sec_tick);
    push("presc_quiet", 0);  tick(3); pop_check(bus.sec_tick);
    push("presc_first", 1);  tick(1); pop_check(bus.sec_tick);
    push("wrap_midnight", tm(0, 0, 0)); tick(5); pop_check(obs_time());

    // hours edit while live keeps running, then commit
    tick();
    bus.display_mode_in = 3'b001;
    push("hours_shadow", tm(3, 0, 0));
    bus.increment_hours_en = 1'b1; tick(3); bus.increment_hours_en = 1'b0; #1;
    pop_check(obs_time());
    bus.display_mode_in = 3'b101; #1;
    push("live_runs", tm(0, 0, 1)); pop_check(obs_time());
    bus.display_mode_in = 3'b001;
    push("load_live", tm(3, 0, 0));
    pulse_load();
    bus.display_mode_in = 3'b101; #1;
    pop_check(obs_time());
    push("presc_reset_quiet", 0); tick(3); pop_check(bus.sec_tick);
    push("presc_reset_tick", 1);  tick(1); pop_check(bus.sec_tick);

    // no-carry field wraps on the shadow
    bus.display_mode_in = 3'b010;
    push("min59", tm(3, 59, 0));
    bus.increment_minutes_en = 1'b1; tick(59); bus.increment_minutes_en = 1'b0; #1;
    pop_check(obs_time());
    push("min_wrap", tm(3, 0, 0));
    bus.increment_minutes_en = 1'b1; tick(); bus.increment_minutes_en = 1'b0; #1;
    pop_check(obs_time());
    push("sec59", tm(3, 0, 59));
    bus.increment_seconds_en = 1'b1; tick(59); #1;
    pop_check(obs_time());
    push("sec_wrap", tm(3, 0, 0));
    tick(); bus.increment_seconds_en = 1'b0; #1;
    pop_check(obs_time());
    push("hr_wrap", tm(0, 0, 0));
    bus.increment_hours_en = 1'b1; tick(21); bus.increment_hours_en = 1'b0; #1;
    pop_check(obs_time());

    // alarm registers: 00:02, seconds increment ignored
    bus.set_alarm_mode = 1'b1;
    bus.display_mode_in = 3'b011;
    push("alarm_set", tm(0, 2, 0));
    bus.increment_minutes_en = 1'b1; tick(2); bus.increment_minutes_en = 1'b0;
    bus.increment_seconds_en = 1'b1; tick();  bus.increment_seconds_en = 1'b0; #1;
    pop_check(obs_time());
    bus.display_mode_in = 3'b100; #1;
    push("alarm_mode4", tm(0, 2, 0)); pop_check(obs_time());
    bus.display_mode_in = 3'b001; #1;
    push("shadow_untouched", tm(0, 0, 0)); pop_check(obs_time());

    // shadow 00:01:58, arm and commit; ring for ALARM_SECS seconds
    bus.set_alarm_mode = 1'b0;
    push("shadow_0158", tm(0, 1, 58));
    bus.increment_minutes_en = 1'b1; bus.increment_seconds_en = 1'b1; tick();
    bus.increment_minutes_en = 1'b0; tick(57); bus.increment_seconds_en = 1'b0; #1;
    pop_check(obs_time());
    bus.alarm_en = 1'b1;
    pulse_load();
    bus.display_mode_in = 3'b101; #1;
    push("load_0158", tm(0, 1, 58)); pop_check(obs_time());
    tick(8);
    push("alarm_pre_time", tm(0, 1, 59)); pop_check(obs_time());
    push("alarm_pre", 0);                 pop_check(bus.alarm_active);
    tick(1);
    push("alarm_on_time", tm(0, 2, 0));   pop_check(obs_time());
    push("alarm_on", 1);                  pop_check(bus.alarm_active);
    push("alarm_hold", 1);   tick(11); pop_check(bus.alarm_active);
    push("alarm_expire", 0); tick(1);  pop_check(bus.alarm_active);

    // acknowledge while ringing
    pulse_load(); tick(9);
    push("alarm_on2", 1); pop_check(bus.alarm_active);
    bus.alarm_ack = 1'b1; tick(); bus.alarm_ack = 1'b0; #1;
    push("ack_clear", 0); pop_check(bus.alarm_active);

    // acknowledge on the trigger cycle
    pulse_load(); tick(8);
    bus.alarm_ack = 1'b1; tick(); bus.alarm_ack = 1'b0; #1;
    push("ack_trigger", 0);      pop_check(bus.alarm_active);
    push("ack_trigger_hold", 0); tick(4); pop_check(bus.alarm_active);

    // disarm while ringing
    pulse_load(); tick(9);
    push("alarm_on3", 1); pop_check(bus.alarm_active);
    bus.alarm_en = 1'b0; tick(); #1;
    push("en_clear", 0); pop_check(bus.alarm_active);
    bus.alarm_en = 1'b1;

    // commit landing exactly on alarm time does not ring
    bus.display_mode_in = 3'b010;
    push("shadow_0200", tm(0, 2, 0));
    bus.increment_minutes_en = 1'b1; bus.increment_seconds_en = 1'b1; tick();
    bus.increment_minutes_en = 1'b0; tick(); bus.increment_seconds_en = 1'b0; #1;
    pop_check(obs_time());
    pulse_load();
    bus.display_mode_in = 3'b101; #1;
    push("load_on_alarm_time", tm(0, 2, 0)); pop_check(obs_time());
    push("load_no_trigger", 0);              pop_check(bus.alarm_active);
    push("load_no_trigger_later", 0); tick(6); pop_check(bus.alarm_active);

    // load coincident with sec_tick
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      tick();
      if (bus.sec_tick) found = 1;
    end
    push("tick_found", 1); pop_check(found);
    push("load_beats_tick", tm(0, 2, 0));
    push("load_tick_low", 0);
    pulse_load(); #1;
    pop_check(obs_time());
    pop_check(bus.sec_tick);

    // reset in the middle of a tick
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      tick();
      if (bus.sec_tick) found = 1;
    end
    push("tick_found2", 1); pop_check(found);
    push("midrst_live", tm(0, 0, 0));
    push("midrst_tick", 0);
    push("midrst_alarm", 0);
    rst = 1'b1; #1;
    pop_check(obs_time());
    pop_check(bus.sec_tick);
    pop_check(bus.alarm_active);
    bus.display_mode_in = 3'b001; #1;
    push("midrst_shadow", tm(0, 0, 0)); pop_check(obs_time());
    bus.display_mode_in = 3'b011; #1;
    push("midrst_alarm_regs", tm(0, 0, 0)); pop_check(obs_time());
    tick(2);
    rst = 1'b0;
    bus.display_mode_in = 3'b000;
    push("post_rst_quiet", 0); tick(3); pop_check(bus.sec_tick);
    push("post_rst_tick", 1);  tick(1); pop_check(bus.sec_tick);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
